branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

In-order tracker for in-flight conditional branches, sitting between fetch/execute and the 2-bit saturating-counter predictor. On each accepted fetch-side branch it drives the predictor's request strobe, captures the returned prediction one cycle later and holds it in a FIFO. On each execute-side resolution it retires the oldest entry, drives the predictor's result/taken update, flags mispredictions and flushes wrong-path entries.

## Interface
- DEPTH, 4, queue entries; power of 2, at least 2
- TAG_W, 8, width of the branch tag carried with each entry
- CNT_W, 16, width of the saturating mispredict counter

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  fetch presents a branch
- issue_tag  in  TAG_W  tag of the presented branch
- issue_ready  out  1  high when count < DEPTH
- pred_req  out  1  = issue_valid & issue_ready; drives predictor request
- pred_in  in  1  predictor prediction, valid the cycle after pred_req
- pred_valid  out  1  registered; prediction for last accepted branch is on pred_out
- pred_out  out  1  = pred_in (pass-through)
- pred_tag  out  TAG_W  registered tag matching pred_out
- resolve_valid  in  1  execute resolves the oldest branch
- resolve_taken  in  1  actual outcome
- resolve_ready  out  1  oldest entry resolvable
- upd_result  out  1  = resolve_valid & resolve_ready; drives predictor result
- upd_taken  out  1  = resolve_taken; drives predictor taken
- mispredict  out  1  registered one-cycle pulse
- mispredict_tag  out  TAG_W  tag of the mispredicted branch, held until next mispredict
- miss_count  out  CNT_W  saturating count of mispredicts
- occupancy  out  clog2(DEPTH)+1  current entry count

## Operation
- Storage: DEPTH entries of {tag, pred}. Write pointer, read pointer and count, with pointers wrapping modulo DEPTH.
- Issue accept (issue_valid & issue_ready): write tag at wr_ptr, advance wr_ptr, count+1, and set pending with pending_ptr = old wr_ptr.
- Capture: when pending is set in a cycle, write pred_in into entry pending_ptr at the end of that cycle and clear pending, unless that same cycle starts a new accept.
  - pred_valid = registered pending.
  - pred_tag = registered issue_tag.
- resolve_ready = count != 0 and not (pending and pending_ptr == rd_ptr).
  - If pending targets the head, compare resolve_taken against pred_in instead is NOT allowed. Resolution waits one cycle.
- Resolve accept: compare head pred with resolve_taken, advance rd_ptr, count-1.
  - Match: no further action.
  - Mismatch, at the same edge:
    - mispredict <= 1 and mispredict_tag <= head tag.
    - miss_count increments, saturating at all-ones.
    - Flush all remaining entries: count <= 0 and wr_ptr <= rd_ptr+1.
    - Clear pending, so no capture occurs and pred_valid is 0 next cycle.
    - Drop any issue accepted in the same cycle. Its pred_req still pulses; that is harmless.
- Simultaneous issue and matching resolve: count is unchanged and pointers advance independently.
- Full (count == DEPTH): issue_ready = 0. pred_req stays low.

## Timing
- Reset values: pointers 0, count 0, pending 0, pred_valid 0, pred_tag 0, mispredict 0, mispredict_tag 0, miss_count 0. Hence issue_ready = 1 and resolve_ready = 0.
- Issue latency: accept in cycle N, pred_valid/pred_out/pred_tag in cycle N+1.
- Earliest resolve of a branch is cycle N+1 if it is not at the head; if it is at the head, cycle N+2.
- Predictor update: upd_result/upd_taken are combinational and are sampled by the predictor at the resolving edge.
- Mispredict latency: resolve in cycle M, mispredict high in cycle M+1 only, occupancy 0 in M+1.
- Reset mid-operation: all entries are discarded immediately (asynchronous). No pulse on mispredict or pred_valid.

## Test plan
- Reset then idle:
  - Required: issue_ready=1, resolve_ready=0, occupancy=0, miss_count=0.
- Issue tag 0x11 with pred_in=1 in the following cycle:
  - Required: pred_req pulses in cycle N; pred_valid=1, pred_out=1, pred_tag=0x11 in N+1; resolve_ready=0 in N+1, then 1 in N+2.
  - Then resolve taken=1: upd_result=1, upd_taken=1, no mispredict, occupancy 0.
- Fill 4 entries (tags 1..4), with issue_valid still high:
  - Required: issue_ready=0, pred_req=0. Resolving one entry reopens issue_ready next cycle and pointers wrap correctly on the next 4 issues.
- Entries tag 5 (pred 0), 6, 7 queued; resolve taken=1 while issuing tag 8 in the same cycle:
  - Required: mispredict=1 with mispredict_tag=5 next cycle, occupancy=0, pred_valid=0, miss_count=1. Tags 6, 7 and 8 are gone.
- Force miss_count to all-ones via repeated mispredicts:
  - Required: it stays all-ones on further mispredicts.
- Assert rst with 3 entries queued and pending set:
  - Required: occupancy=0 and pred_valid=0 immediately. The first issue after release is stored at slot 0.

Source files
------------

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_queue
// Description : In-order FIFO of in-flight branches. It captures each
//               prediction, checks it at resolve time and flushes the
//               wrong-path entries when the prediction was wrong.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [TAG_W-1:0]         issue_tag,
    output logic                     issue_ready,
    output logic                     pred_req,
    input  logic                     pred_in,
    output logic                     pred_valid,
    output logic                     pred_out,
    output logic [TAG_W-1:0]         pred_tag,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     resolve_ready,
    output logic                     upd_result,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic [TAG_W-1:0]         mispredict_tag,
    output logic [CNT_W-1:0]         miss_count,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [DEPTH-1:0] pred_mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] pending_ptr;
    logic [OCC_W-1:0] count;
    logic             pending;
    logic             issue_acc;
    logic             res_acc;
    logic             miss;

    assign issue_ready   = (count < OCC_W'(DEPTH));
    // The head's prediction is only written at the end of its capture cycle.
    assign resolve_ready = (count != '0) && !(pending && (pending_ptr == rd_ptr));
    assign pred_req      = issue_valid & issue_ready;
    assign upd_result    = resolve_valid & resolve_ready;
    assign upd_taken     = resolve_taken;
    assign pred_out      = pred_in;
    assign pred_valid    = pending;
    assign occupancy     = count;

    assign issue_acc = pred_req;
    assign res_acc   = upd_result;
    assign miss      = res_acc && (pred_mem[rd_ptr] != resolve_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pending_ptr    <= '0;
            count          <= '0;
            pending        <= 1'b0;
            pred_tag       <= '0;
            mispredict     <= 1'b0;
            mispredict_tag <= '0;
            miss_count     <= '0;
        end else begin
            if (res_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (miss) begin
                // Wrong path: the queue empties and a same-cycle issue is dropped.
                count   <= '0;
                wr_ptr  <= rd_ptr + 1'b1;
                pending <= 1'b0;
            end else begin
                if (issue_acc) begin
                    wr_ptr      <= wr_ptr + 1'b1;
                    pending     <= 1'b1;
                    pending_ptr <= wr_ptr;
                    pred_tag    <= issue_tag;
                end else begin
                    pending <= 1'b0;
                end
                case ({issue_acc, res_acc})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
            mispredict <= miss;
            if (miss) begin
                mispredict_tag <= tag_mem[rd_ptr];
                if (miss_count != '1) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
        end
    end

    // Entry storage needs no reset; occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (pending && !miss) begin
            pred_mem[pending_ptr] <= pred_in;
        end
        if (issue_acc && !miss) begin
            tag_mem[wr_ptr] <= issue_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_queue
// Description : Directed self-checking bench for branch_resolve_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [7:0] issue_tag;
    logic       issue_ready;
    logic       pred_req;
    logic       pred_in;
    logic       pred_valid;
    logic       pred_out;
    logic [7:0] pred_tag;
    logic       resolve_valid;
    logic       resolve_taken;
    logic       resolve_ready;
    logic       upd_result;
    logic       upd_taken;
    logic       mispredict;
    logic [7:0] mispredict_tag;
    logic [1:0] miss_count;
    logic [2:0] occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH(4), .TAG_W(8), .CNT_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_tag      (issue_tag),
        .issue_ready    (issue_ready),
        .pred_req       (pred_req),
        .pred_in        (pred_in),
        .pred_valid     (pred_valid),
        .pred_out       (pred_out),
        .pred_tag       (pred_tag),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .resolve_ready  (resolve_ready),
        .upd_result     (upd_result),
        .upd_taken      (upd_taken),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .miss_count     (miss_count),
        .occupancy      (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one branch predicted not-taken, then resolve it as taken.
    task automatic do_miss(input logic [7:0] t);
        cyc(); issue_valid = 1'b1; issue_tag = t;
        cyc(); issue_valid = 1'b0; pred_in = 1'b0;
        cyc(); resolve_valid = 1'b1; resolve_taken = 1'b1;
        cyc(); resolve_valid = 1'b0; #1;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; pred_in = 1'b0;
        resolve_valid = 1'b0; resolve_taken = 1'b0;
        cyc(); cyc();
        rst = 1'b0; #1;
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_resolve_ready", resolve_ready, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_mispredict", mispredict, 0);

        // Single branch, correctly predicted taken
        cyc(); issue_valid = 1'b1; issue_tag = 8'h11; #1;
        chk("t1_pred_req", pred_req, 1);
        cyc(); issue_valid = 1'b0; pred_in = 1'b1; #1;
        chk("t1_pred_valid", pred_valid, 1);
        chk("t1_pred_out", pred_out, 1);
        chk("t1_pred_tag", pred_tag, 8'h11);
        chk("t1_resolve_blocked", resolve_ready, 0);
        chk("t1_occupancy", occupancy, 1);
        cyc(); pred_in = 1'b0; #1;
        chk("t1_resolve_ready", resolve_ready, 1);
        chk("t1_pred_valid_low", pred_valid, 0);
        resolve_valid = 1'b1; resolve_taken = 1'b1; #1;
        chk("t1_upd_result", upd_result, 1);
        chk("t1_upd_taken", upd_taken, 1);
        cyc(); resolve_valid = 1'b0; #1;
        chk("t1_no_mispredict", mispredict, 0);
        chk("t1_occupancy_empty", occupancy, 0);

        // Fill all four slots, keep pushing while full
        pred_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc(); issue_valid = 1'b1; issue_tag = i[7:0]; #1;
            chk("fill_pred_req", pred_req, 1);
        end
        cyc(); issue_tag = 8'h05; #1;
        chk("full_issue_ready", issue_ready, 0);
        chk("full_pred_req", pred_req, 0);
        chk("full_occupancy", occupancy, 4);
        chk("full_pred_valid", pred_valid, 1);
        cyc(); resolve_valid = 1'b1; resolve_taken = 1'b1; #1;
        chk("full_resolve_ready", resolve_ready, 1);
        chk("full_still_blocked", issue_ready, 0);
        cyc(); issue_valid = 1'b0; #1;
        chk("reopen_issue_ready", issue_ready, 1);
        chk("reopen_occupancy", occupancy, 3);
        chk("reopen_no_mispredict", mispredict, 0);
        cyc(); #1;
        chk("drain_occupancy2", occupancy, 2);
        cyc(); #1;
        chk("drain_occupancy1", occupancy, 1);
        cyc(); resolve_valid = 1'b0; #1;
        chk("drain_occupancy0", occupancy, 0);
        chk("drain_resolve_ready", resolve_ready, 0);
        chk("drain_no_mispredict", mispredict, 0);

        // Mispredict on wrapped entries with a same-cycle issue
        cyc(); issue_valid = 1'b1; issue_tag = 8'h05;
        cyc(); issue_tag = 8'h06; pred_in = 1'b0;
        cyc(); issue_tag = 8'h07; pred_in = 1'b1;
        cyc(); issue_valid = 1'b0; pred_in = 1'b1; #1;
        chk("mp_occupancy_before", occupancy, 3);
        cyc(); resolve_valid = 1'b1; resolve_taken = 1'b1;
        issue_valid = 1'b1; issue_tag = 8'h08; #1;
        chk("mp_resolve_ready", resolve_ready, 1);
        chk("mp_pred_req", pred_req, 1);
        cyc(); resolve_valid = 1'b0; issue_valid = 1'b0; #1;
        chk("mp_mispredict", mispredict, 1);
        chk("mp_tag", mispredict_tag, 8'h05);
        chk("mp_occupancy", occupancy, 0);
        chk("mp_pred_valid", pred_valid, 0);
        chk("mp_miss_count", miss_count, 1);
        chk("mp_resolve_ready_low", resolve_ready, 0);
        cyc(); #1;
        chk("mp_pulse_end", mispredict, 0);

        // Saturating mispredict counter
        do_miss(8'h21);
        chk("sat_tag1", mispredict_tag, 8'h21);
        chk("sat_count2", miss_count, 2);
        do_miss(8'h22);
        chk("sat_count3", miss_count, 3);
        do_miss(8'h23);
        chk("sat_hold", miss_count, 3);
        chk("sat_tag3", mispredict_tag, 8'h23);
        chk("sat_pulse", mispredict, 1);

        // Asynchronous reset with entries queued and pending set
        cyc(); issue_valid = 1'b1; issue_tag = 8'hA1; pred_in = 1'b1;
        cyc(); issue_tag = 8'hA2;
        cyc(); issue_tag = 8'hA3;
        cyc(); issue_valid = 1'b0; #1;
        chk("pre_rst_occupancy", occupancy, 3);
        chk("pre_rst_pred_valid", pred_valid, 1);
        rst = 1'b1; #1;
        chk("arst_occupancy", occupancy, 0);
        chk("arst_pred_valid", pred_valid, 0);
        chk("arst_miss_count", miss_count, 0);
        chk("arst_issue_ready", issue_ready, 1);
        cyc(); rst = 1'b0; #1;
        chk("post_rst_mispredict", mispredict, 0);
        cyc(); issue_valid = 1'b1; issue_tag = 8'hD0;
        cyc(); issue_valid = 1'b0; pred_in = 1'b0; #1;
        chk("post_rst_pred_tag", pred_tag, 8'hD0);
        chk("post_rst_resolve_blocked", resolve_ready, 0);
        cyc(); resolve_valid = 1'b1; resolve_taken = 1'b1; #1;
        chk("post_rst_resolve_ready", resolve_ready, 1);
        cyc(); resolve_valid = 1'b0; #1;
        chk("post_rst_mispredict_pulse", mispredict, 1);
        chk("post_rst_tag", mispredict_tag, 8'hD0);
        chk("post_rst_miss_count", miss_count, 1);
        chk("post_rst_occupancy", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
